// File: rtl/fifo_reader.sv
// fifo_reader: drains a synchronous FIFO with ren pulses and presents its words downstream as a valid/ready stream.
// Latency: a ren issued in cycle t yields m_valid with that word in cycle t+2; sustains one word per cycle.
// Backpressure: m_ready=0 stalls pops; reads keep being issued until buffered plus in-flight words fill BUF_DEPTH.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, shared with the attached FIFO
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered data_out, meaningful only the cycle after a ren
//   fifo_ren    FIFO read enable
//   m_valid     stream word available
//   m_ready     consumer accepts the word (transfer on m_valid && m_ready)
//   m_data      stream word
//   rd_count    delivered-word counter, present only when FIFO_READER_CNT_EN is defined
//
// Optional feature macro: FIFO_READER_CNT_EN (adds rd_count).
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  // count must be able to hold BUF_DEPTH itself, hence one extra bit.
  localparam int CNT_W = PTR_W + 1;
  // count + inflight can reach BUF_DEPTH + 1 in width terms; keep headroom.
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(BUF_DEPTH);

  // Elaboration-time parameter sanity checks.
  if ((BUF_DEPTH < 4) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_reader: BUF_DEPTH must be a power of two and at least 4");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("fifo_reader: CNT_WIDTH must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  inflight;
  logic [OCC_W-1:0]      occupancy;
  logic                  capture;
  logic                  pop;

  // Every issued read owns a buffer slot until its word is popped, so the
  // buffer can never overflow. Issue depends only on registers, fifo_empty
  // and reset, never on m_ready, keeping the consumer off the FIFO timing path.
  // Gating with reset keeps ren low while the FIFO itself is held in reset.
  assign occupancy = {1'b0, count} + OCC_W'(inflight);
  assign fifo_ren  = reset && !fifo_empty && (occupancy < DEPTH_V);

  assign capture = inflight;
  assign pop     = m_valid && m_ready;

  assign m_valid = (count != '0);
  assign m_data  = mem[rptr];

  always_comb begin
    count_nxt = count;
    unique case ({capture, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO data_out is registered, so the word for a ren in cycle t is
  // present on fifo_data during t+1; inflight marks that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      inflight <= fifo_ren;
      count    <= count_nxt;
      if (capture) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // Storage is cleared on reset so m_data reads 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (capture) begin
      mem[wptr] <= fifo_data;
    end
  end

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Read-side companion for the team's synchronous FIFO (wen/ren, full/half/empty, registered data_out). It drains the FIFO by issuing ren pulses and absorbs the FIFO's one-cycle read latency in a small internal buffer. It presents the words downstream as a valid/ready stream. It sits between the FIFO's read port and any stream consumer, so consumers never drive ren directly and never see read-latency bubbles.

Parameters:
DATA_WIDTH, 8, width of a FIFO word and of m_data.
BUF_DEPTH, 4, internal prefetch buffer entries; must be a power of two and at least 4.
CNT_WIDTH, 16, width of rd_count (used only with the optional feature).

Ports:
clk  input  1  single clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted); must be shared with the attached FIFO.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO data_out; valid in the cycle after the ren cycle.
fifo_ren  output  1  read enable to FIFO.
m_valid  output  1  stream word available.
m_ready  input  1  consumer accepts the word; a transfer happens when m_valid && m_ready.
m_data  output  DATA_WIDTH  stream word.
rd_count  output  CNT_WIDTH  delivered-word counter (present only when FIFO_READER_CNT_EN is defined).

Behaviour:
- Reset (reset=0, async), applied immediately:
  - buffer count=0, write/read pointers=0, inflight=0
  - m_valid=0, m_data=0, fifo_ren=0, rd_count=0
- Reset mid-operation: any in-flight read is discarded and the buffer is flushed. The FIFO resets on the same reset, so no word is lost relative to the FIFO contents.
- Read issue (combinational from registers and fifo_empty only):
  - fifo_ren = !fifo_empty && (count + inflight < BUF_DEPTH).
  - fifo_ren has no combinational path from m_ready.
- inflight register: inflight <= fifo_ren each cycle.
- Capture: when inflight=1, fifo_data is written into buffer[wptr] at the rising edge, and wptr increments modulo BUF_DEPTH.
- Pop: when m_valid && m_ready, rptr increments modulo BUF_DEPTH.
- Count update:
  - capture and pop in the same cycle: count unchanged
  - capture only: count+1
  - pop only: count-1
- Overflow: count never exceeds BUF_DEPTH, because the issue rule reserves a slot for every in-flight read.
- Outputs:
  - m_valid = (count != 0).
  - m_data = buffer[rptr], registered storage.
  - m_data is held stable while m_valid && !m_ready.
- Ordering: words leave in exactly the order they were read from the FIFO.
- Latency: FIFO goes non-empty with the buffer idle → fifo_ren in cycle t → m_valid=1 in cycle t+2 carrying that word.
- Throughput: one word per cycle sustained while the FIFO is non-empty and m_ready=1.
- FIFO empty: no ren is issued. The buffer keeps delivering until count=0; then m_valid=0.
- Back-pressure: with m_ready=0, reads continue until count+inflight=BUF_DEPTH, then fifo_ren=0 until a pop frees a slot.
- fifo_data is ignored in any cycle where inflight=0.

Optional Feature:
FIFO_READER_CNT_EN:
- Defined: port rd_count exists. It increments by 1 on every m_valid && m_ready transfer, wraps from 2^CNT_WIDTH-1 to 0, and clears on reset.
- Undefined: the rd_count port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: FIFO empty, m_ready=1 for 10 cycles → fifo_ren=0, m_valid=0, m_data=0 throughout.
- Single word: FIFO holds 8'h24, m_ready=1 → one fifo_ren pulse in cycle t; m_valid=1 with m_data=8'h24 only in cycle t+2; then m_valid=0.
- Streaming: 8 words 8'h24,8'h81,8'h09,8'h63,8'h0D,8'h8D,8'h65,8'h12 prefilled, m_ready=1 → 8 consecutive transfers in that order, no bubbles after the first; rd_count=8 with FIFO_READER_CNT_EN.
- Back-pressure: same 8 words, m_ready=0 → exactly 4 ren pulses, m_data stays 8'h24. Release m_ready=1 → remaining words delivered in order; total ren pulses=8.
- Wrap and simultaneous events: 20 words (values 0..19) with m_ready toggling every cycle → all 20 received in order, and count never exceeds 4.
- Reset mid-stream: assert reset=0 with count=3 → m_valid and fifo_ren drop immediately; after release with the FIFO empty, m_valid stays 0 and rd_count=0.
